// File: rtl/anita_l0_scaler_counter.sv
// L0 scaler counter bank: gated per-channel pulse counters with saturating overflow,
// a holding bank latched at each gate end, and a small read port for register readout.
module anita_l0_scaler_counter #(
    parameter int NCH         = 12,
    parameter int CW          = 16,
    parameter int GATE_CYCLES = 33000000
) (
    input  logic           mclk_i,
    input  logic           rst_n_i,
    input  logic [NCH-1:0] pulse_i,
    input  logic           enable_i,
    input  logic           rd_i,
    input  logic [3:0]     addr_i,
    input  logic           ack_i,
    output logic [31:0]    rdata_o,
    output logic           rvalid_o,
    output logic           new_o,
    output logic           gate_o
);

    localparam int              TW    = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0]   TLOAD = TW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0]   CMAX  = '1;
    localparam logic [3:0]      NCH4  = 4'(NCH);

    // Down-counter: TLOAD is the first cycle of a gate, zero is the latch cycle.
    logic [TW-1:0]  r_timer;
    logic [CW-1:0]  r_cnt  [NCH];
    logic [CW-1:0]  r_hold [NCH];
    logic [NCH-1:0] r_ovf;
    logic [NCH-1:0] r_hold_ovf;
    logic [15:0]    r_period;
    logic           r_missed;

    logic           w_latch;
    logic [CW-1:0]  w_cnt_nxt [NCH];
    logic [NCH-1:0] w_ovf_nxt;
    logic [31:0]    w_rdata;

    assign w_latch = enable_i && (r_timer == '0);

    // Next count includes this cycle's pulse so the latch captures it.
    always_comb begin
        w_ovf_nxt = r_ovf;
        for (int n = 0; n < NCH; n++) begin
            w_cnt_nxt[n] = r_cnt[n];
            if (pulse_i[n]) begin
                if (r_cnt[n] == CMAX) w_ovf_nxt[n] = 1'b1;
                else                  w_cnt_nxt[n] = r_cnt[n] + 1'b1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (addr_i < NCH4)
            w_rdata = {15'b0, r_hold_ovf[addr_i], 16'(r_hold[addr_i])};
        else if (addr_i == 4'hF)
            w_rdata = {r_missed, 3'b0, 12'(r_hold_ovf), r_period};
    end

    always_ff @(posedge mclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_timer <= TLOAD;
        end else if (!enable_i || r_timer == '0) begin
            r_timer <= TLOAD;
        end else begin
            r_timer <= r_timer - 1'b1;
        end
    end

    always_ff @(posedge mclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int n = 0; n < NCH; n++) begin
                r_cnt[n]  <= '0;
                r_hold[n] <= '0;
            end
            r_ovf      <= '0;
            r_hold_ovf <= '0;
        end else if (!enable_i) begin
            for (int n = 0; n < NCH; n++) r_cnt[n] <= '0;
            r_ovf <= '0;
        end else if (w_latch) begin
            for (int n = 0; n < NCH; n++) begin
                r_hold[n] <= w_cnt_nxt[n];
                r_cnt[n]  <= '0;
            end
            r_hold_ovf <= w_ovf_nxt;
            r_ovf      <= '0;
        end else begin
            for (int n = 0; n < NCH; n++) r_cnt[n] <= w_cnt_nxt[n];
            r_ovf <= w_ovf_nxt;
        end
    end

    // A latch takes priority over a simultaneous acknowledge.
    always_ff @(posedge mclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_period <= '0;
            new_o    <= 1'b0;
            r_missed <= 1'b0;
        end else if (w_latch) begin
            r_period <= r_period + 1'b1;
            new_o    <= 1'b1;
            if (new_o && !ack_i) r_missed <= 1'b1;
        end else if (ack_i) begin
            new_o    <= 1'b0;
            r_missed <= 1'b0;
        end
    end

    always_ff @(posedge mclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
            gate_o   <= 1'b0;
        end else begin
            rvalid_o <= rd_i;
            gate_o   <= w_latch;
            if (rd_i) rdata_o <= w_rdata;
        end
    end

endmodule

// File: tb/tb_anita_l0_scaler_counter.sv
// Bench for anita_l0_scaler_counter: a CW=16 and a CW=4 instance share one stimulus
// stream and are checked every cycle against a gate-period model, plus literal checkpoints.
module tb_anita_l0_scaler_counter;

    localparam int NCH  = 12;
    localparam int GATE = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] pulse;
    logic        en, rd, ack;
    logic [3:0]  addr;

    logic [31:0] rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b, new_a, new_b, gate_a, gate_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    anita_l0_scaler_counter #(.NCH(NCH), .CW(16), .GATE_CYCLES(GATE)) dut_a (
        .mclk_i(clk), .rst_n_i(rst_n), .pulse_i(pulse), .enable_i(en), .rd_i(rd),
        .addr_i(addr), .ack_i(ack), .rdata_o(rdata_a), .rvalid_o(rvalid_a),
        .new_o(new_a), .gate_o(gate_a));

    anita_l0_scaler_counter #(.NCH(NCH), .CW(4), .GATE_CYCLES(GATE)) dut_b (
        .mclk_i(clk), .rst_n_i(rst_n), .pulse_i(pulse), .enable_i(en), .rd_i(rd),
        .addr_i(addr), .ack_i(ack), .rdata_o(rdata_b), .rvalid_o(rvalid_b),
        .new_o(new_b), .gate_o(gate_b));

    // Model state, index 0 = CW 16 instance, 1 = CW 4 instance.
    int unsigned m_cnt    [2][NCH];
    bit          m_ovf    [2][NCH];
    int unsigned m_hold   [2][NCH];
    bit          m_hovf   [2][NCH];
    int unsigned m_period [2];
    bit          m_new    [2];
    bit          m_missed [2];
    bit [31:0]   m_rdata  [2];
    bit          m_rvalid [2];
    bit          m_gate   [2];
    int unsigned m_run;
    int unsigned cmax [2] = '{65535, 15};

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h at %0t", nm, k, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] m_read(input int k, input int a);
        bit [31:0] r;
        r = '0;
        if (a < NCH) begin
            r = m_hold[k][a];
            r[16] = m_hovf[k][a];
        end else if (a == 15) begin
            r = m_period[k] % 65536;
            for (int n = 0; n < NCH; n++) r[16+n] = m_hovf[k][n];
            r[31] = m_missed[k];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        bit latch;
        int unsigned v;
        bit o;
        if (!rst_n) begin
            m_run = 0;
            for (int k = 0; k < 2; k++) begin
                for (int n = 0; n < NCH; n++) begin
                    m_cnt[k][n] = 0; m_ovf[k][n] = 0; m_hold[k][n] = 0; m_hovf[k][n] = 0;
                end
                m_period[k] = 0; m_new[k] = 0; m_missed[k] = 0;
                m_rdata[k] = 0; m_rvalid[k] = 0; m_gate[k] = 0;
            end
        end else begin
            latch = en && (m_run % GATE == GATE - 1);
            for (int k = 0; k < 2; k++) begin
                m_rvalid[k] = rd;
                if (rd) m_rdata[k] = m_read(k, int'(addr));
                m_gate[k] = latch;
                for (int n = 0; n < NCH; n++) begin
                    if (!en) begin
                        m_cnt[k][n] = 0; m_ovf[k][n] = 0;
                    end else begin
                        v = m_cnt[k][n] + pulse[n];
                        o = m_ovf[k][n];
                        if (v > cmax[k]) begin v = cmax[k]; o = 1; end
                        if (latch) begin
                            m_hold[k][n] = v; m_hovf[k][n] = o;
                            m_cnt[k][n] = 0;  m_ovf[k][n] = 0;
                        end else begin
                            m_cnt[k][n] = v;  m_ovf[k][n] = o;
                        end
                    end
                end
                if (latch) begin
                    if (m_new[k] && !ack) m_missed[k] = 1;
                    m_new[k] = 1;
                    m_period[k] = (m_period[k] + 1) % 65536;
                end else if (ack) begin
                    m_new[k] = 0; m_missed[k] = 0;
                end
            end
            m_run = en ? m_run + 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("rvalid", 0, {31'b0, rvalid_a}, {31'b0, m_rvalid[0]});
            chk("rvalid", 1, {31'b0, rvalid_b}, {31'b0, m_rvalid[1]});
            chk("gate",   0, {31'b0, gate_a},   {31'b0, m_gate[0]});
            chk("gate",   1, {31'b0, gate_b},   {31'b0, m_gate[1]});
            chk("new",    0, {31'b0, new_a},    {31'b0, m_new[0]});
            chk("new",    1, {31'b0, new_b},    {31'b0, m_new[1]});
            chk("rdata",  0, rdata_a, m_rdata[0]);
            chk("rdata",  1, rdata_b, m_rdata[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [3:0] a);
        rd = 1'b1; addr = a;
        tick();
        rd = 1'b0;
    endtask

    // Literal expectation on both the DUT read data and the model's own prediction.
    task automatic lit(input string nm, input logic [31:0] ea, input logic [31:0] eb);
        chk(nm, 0, rdata_a, ea);
        chk(nm, 1, rdata_b, eb);
        chk({"model ", nm}, 0, m_rdata[0], ea);
        chk({"model ", nm}, 1, m_rdata[1], eb);
    endtask

    task automatic wait_gate();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * GATE && !seen; i++) begin
            tick();
            if (gate_a) seen = 1'b1;
        end
        chk("gate_wait", 0, {31'b0, seen}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int gap;
        rst_n = 1'b0; pulse = '0; en = 1'b0; rd = 1'b0; ack = 1'b0; addr = '0;
        repeat (3) tick();
        chk("reset rdata",  0, rdata_a, 32'h0);
        chk("reset rvalid", 0, {31'b0, rvalid_a}, 32'h0);
        chk("reset new",    1, {31'b0, new_b}, 32'h0);
        chk("reset gate",   1, {31'b0, gate_b}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Ten ch0 pulses and 37 ch11 pulses inside the first gate.
        en = 1'b1;
        for (int i = 0; i < GATE; i++) begin
            pulse = '0;
            pulse[0]  = (i < 10);
            pulse[11] = (i < 37);
            tick();
        end
        pulse = '0;
        chk("first gate", 0, {31'b0, gate_a}, 32'd1);
        chk("first new",  1, {31'b0, new_b},  32'd1);
        do_read(4'd0);  lit("ch0", 32'h0000_000A, 32'h0000_000A);
        do_read(4'd11); lit("ch11", 32'h0000_0025, 32'h0001_000F);
        do_read(4'd15); lit("status1", 32'h0000_0001, 32'h0800_0001);

        // ch3 held high across the latch and through a whole period.
        pulse[3] = 1'b1;
        wait_gate();
        repeat (GATE) tick();
        pulse = '0;
        chk("full period gate", 0, {31'b0, gate_a}, 32'd1);
        do_read(4'd3); lit("ch3 full", 32'd100, 32'h0001_000F);

        pulse[5] = 1'b1;
        repeat (20) tick();
        pulse = '0;
        wait_gate();
        do_read(4'd5); lit("ch5 20", 32'h0000_0014, 32'h0001_000F);
        wait_gate();
        do_read(4'd5); lit("ch5 empty", 32'h0, 32'h0);

        // Unacknowledged gates set missed; ack clears; ack on the latch cycle loses.
        do_read(4'd15);
        chk("missed set", 0, {31'b0, rdata_a[31]}, 32'd1);
        chk("missed set", 1, {31'b0, rdata_b[31]}, 32'd1);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("ack new", 0, {31'b0, new_a}, 32'd0);
        do_read(4'd15);
        chk("missed clr", 0, {31'b0, rdata_a[31]}, 32'd0);
        wait_gate();
        repeat (GATE - 1) tick();
        ack = 1'b1; tick(); ack = 1'b0;
        chk("ack on latch gate", 0, {31'b0, gate_a}, 32'd1);
        chk("ack on latch new",  0, {31'b0, new_a},  32'd1);
        chk("ack on latch new",  1, {31'b0, new_b},  32'd1);
        do_read(4'd15);
        chk("missed kept", 0, {31'b0, rdata_a[31]}, 32'd0);

        // Disabled: pulses ignored, no gate; re-enable gives gate_o in the 101st cycle.
        en = 1'b0;
        for (int i = 0; i < 250; i++) begin
            pulse = 12'($urandom);
            tick();
            chk("idle gate", 0, {31'b0, gate_a}, 32'd0);
        end
        pulse = '0;
        en = 1'b1;
        gap = 0;
        for (int i = 0; i < 3 * GATE && !gate_a; i++) begin
            tick();
            gap++;
        end
        chk("enable to gate", 0, gap, GATE);

        // Asynchronous reset mid-period with new_o and rvalid_o set.
        repeat (30) tick();
        do_read(4'd0);
        chk("pre-reset new", 0, {31'b0, new_a}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst rdata",  0, rdata_a, 32'h0);
        chk("async rst rvalid", 0, {31'b0, rvalid_a}, 32'h0);
        chk("async rst new",    0, {31'b0, new_a}, 32'h0);
        chk("async rst new",    1, {31'b0, new_b}, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        do_read(4'd15); lit("status after reset", 32'h0, 32'h0);

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            pulse = 12'($urandom) & 12'($urandom);
            if (en && $urandom_range(0, 299) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
            rd   = ($urandom_range(0, 3) == 0);
            addr = 4'($urandom_range(0, 15));
            ack  = ($urandom_range(0, 120) == 0);
            tick();
        end
        pulse = '0; rd = 1'b0; ack = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
